// File: rtl/sma_in_edge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sma_in_edge_ctrl
// Function : SMA input synchronizer, glitch filter and edge capture with an
//            Avalon-MM register file. SMA_IN_TIMESTAMP_EN builds the timestamp.
// Revision : 1.0
// ============================================================================
module sma_in_edge_ctrl #(
    parameter logic [7:0] FILTER_RST = 8'd4,
    parameter int         CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_port,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);
    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_QUAL_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_QUAL_LOW  = 2'd3
    } state_t;

    localparam logic [2:0]       C_ADDR_DATA   = 3'd0;
    localparam logic [2:0]       C_ADDR_CTRL   = 3'd1;
    localparam logic [2:0]       C_ADDR_STATUS = 3'd2;
    localparam logic [2:0]       C_ADDR_COUNT  = 3'd3;
    localparam logic [2:0]       C_ADDR_TSTAMP = 3'd4;
    localparam logic [2:0]       C_ADDR_FILTER = 3'd5;
    localparam logic [CNT_W-1:0] C_CNT_MAX     = '1;

    logic             sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic [7:0]       qcnt_q, qcnt_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic             pol_q, pol_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       filter_q, filter_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             w_sync_in, w_level, w_rise, w_fall, w_wr, w_capture, w_latch;
    logic [31:0]      w_ts_rd;
    logic             unused_ok;

    assign w_sync_in = sync2_q;
    assign w_level   = (state_q == ST_HIGH) || (state_q == ST_QUAL_LOW);
    assign w_wr      = chipselect & ~write_n;
    assign readdata  = readdata_q;
    assign irq       = irq_q;

    // Filter: a new level must persist through FILTER+1 comparisons in QUAL_x.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        w_rise  = 1'b0;
        w_fall  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (w_sync_in) begin
                    state_d = ST_QUAL_HIGH;
                    qcnt_d  = 8'd0;
                end
            end
            ST_QUAL_HIGH: begin
                if (!w_sync_in) begin
                    state_d = ST_LOW;
                end else if (qcnt_q >= filter_q) begin
                    state_d = ST_HIGH;
                    w_rise  = 1'b1;
                end else begin
                    qcnt_d = qcnt_q + 8'd1;
                end
            end
            ST_HIGH: begin
                if (!w_sync_in) begin
                    state_d = ST_QUAL_LOW;
                    qcnt_d  = 8'd0;
                end
            end
            ST_QUAL_LOW: begin
                if (w_sync_in) begin
                    state_d = ST_HIGH;
                end else if (qcnt_q >= filter_q) begin
                    state_d = ST_LOW;
                    w_fall  = 1'b1;
                end else begin
                    qcnt_d = qcnt_q + 8'd1;
                end
            end
            default: state_d = ST_LOW;
        endcase
    end

    // Bus writes are applied first so a coincident capture wins over W1C/clear.
    always_comb begin
        ctrl_d     = ctrl_q;
        filter_d   = filter_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        pol_d      = pol_q;
        count_d    = count_q;
        w_latch    = 1'b0;
        w_capture  = ctrl_q[0] & ((w_rise & ctrl_q[1]) | (w_fall & ctrl_q[2]));

        if (w_wr && address == C_ADDR_CTRL)   ctrl_d   = writedata[3:0];
        if (w_wr && address == C_ADDR_FILTER) filter_d = writedata[7:0];
        if (w_wr && address == C_ADDR_STATUS) begin
            if (writedata[0]) pending_d  = 1'b0;
            if (writedata[1]) overflow_d = 1'b0;
        end
        if (w_wr && address == C_ADDR_COUNT)  count_d  = '0;

        if (w_capture) begin
            if (!pending_d) begin
                pending_d = 1'b1;
                pol_d     = w_rise;
                w_latch   = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
            if (count_d != C_CNT_MAX) count_d = count_d + CNT_W'(1);
        end

        irq_d = ctrl_q[3] & pending_q;

        case (address)
            C_ADDR_DATA:   readdata_d = {31'd0, w_level};
            C_ADDR_CTRL:   readdata_d = {28'd0, ctrl_q};
            C_ADDR_STATUS: readdata_d = {29'd0, pol_q, overflow_q, pending_q};
            C_ADDR_COUNT:  readdata_d = 32'(count_q);
            C_ADDR_TSTAMP: readdata_d = w_ts_rd;
            C_ADDR_FILTER: readdata_d = {24'd0, filter_q};
            default:       readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= ST_LOW;
            qcnt_q     <= 8'd0;
            ctrl_q     <= 4'd0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            pol_q      <= 1'b0;
            count_q    <= '0;
            filter_q   <= FILTER_RST;
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            ctrl_q     <= ctrl_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            pol_q      <= pol_d;
            count_q    <= count_d;
            filter_q   <= filter_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

`ifdef SMA_IN_TIMESTAMP_EN
    logic [31:0] frc_q, frc_d, tstamp_q, tstamp_d;

    always_comb begin
        frc_d    = frc_q + 32'd1;
        tstamp_d = w_latch ? frc_q : tstamp_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frc_q    <= 32'd0;
            tstamp_q <= 32'd0;
        end else begin
            frc_q    <= frc_d;
            tstamp_q <= tstamp_d;
        end
    end

    assign w_ts_rd   = tstamp_q;
    assign unused_ok = &{1'b0, writedata[31:8]};
`else
    assign w_ts_rd   = 32'd0;
    assign unused_ok = &{1'b0, writedata[31:8], w_latch};
`endif

endmodule
`default_nettype wire

// File: tb/tb_sma_in_edge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sma_in_edge_ctrl
// Function : Self-checking bench for sma_in_edge_ctrl (default and CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_sma_in_edge_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_port = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata, readdata4;
    logic        irq, irq4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sma_in_edge_ctrl #(.FILTER_RST(8'd4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq));

    sma_in_edge_ctrl #(.FILTER_RST(8'd4), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata4), .irq(irq4));

    // Spec-level model: the level flips once the opposite value has been seen
    // for FILTER+2 consecutive cycles; captures follow the register rules.
    logic [1:0]  m_dly = 2'b00;
    logic        m_level = 1'b0, m_pend = 1'b0, m_ovf = 1'b0, m_pol = 1'b0;
    logic [3:0]  m_ctrl = 4'd0;
    logic [7:0]  m_filter = 8'd4;
    logic [31:0] m_time = 32'd0, m_tstamp = 32'd0, m_ts_rd;
    int          m_run = 0, m_cnt = 0, m_cnt4 = 0;
    logic [31:0] m_rd = 32'd0, m_rd4 = 32'd0;
    logic        m_irq = 1'b0;
    logic        m_wr, m_s, m_er, m_ef, m_cap;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_dly = 2'b00; m_level = 0; m_pend = 0; m_ovf = 0; m_pol = 0;
            m_ctrl = 0; m_filter = 8'd4; m_time = 0; m_tstamp = 0;
            m_run = 0; m_cnt = 0; m_cnt4 = 0; m_rd = 0; m_rd4 = 0; m_irq = 0;
        end else begin
            m_wr = chipselect && !write_n;
`ifdef SMA_IN_TIMESTAMP_EN
            m_ts_rd = m_tstamp;
`else
            m_ts_rd = 32'd0;
`endif
            case (address)
                3'd0: m_rd = {31'd0, m_level};
                3'd1: m_rd = {28'd0, m_ctrl};
                3'd2: m_rd = {29'd0, m_pol, m_ovf, m_pend};
                3'd3: m_rd = 32'(m_cnt);
                3'd4: m_rd = m_ts_rd;
                3'd5: m_rd = {24'd0, m_filter};
                default: m_rd = 32'd0;
            endcase
            m_rd4 = (address == 3'd3) ? 32'(m_cnt4) : m_rd;
            m_irq = m_ctrl[3] & m_pend;

            m_s = m_dly[1];
            m_dly = {m_dly[0], in_port};
            m_er = 1'b0;
            m_ef = 1'b0;
            if (m_s != m_level) begin
                m_run++;
                if (m_run >= int'(m_filter) + 2) begin
                    m_er = m_s;
                    m_ef = !m_s;
                    m_level = m_s;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end

            if (m_wr && address == 3'd2) begin
                if (writedata[0]) m_pend = 1'b0;
                if (writedata[1]) m_ovf = 1'b0;
            end
            if (m_wr && address == 3'd3) begin
                m_cnt = 0;
                m_cnt4 = 0;
            end
            m_cap = m_ctrl[0] && ((m_er && m_ctrl[1]) || (m_ef && m_ctrl[2]));
            if (m_cap) begin
                if (!m_pend) begin
                    m_pend = 1'b1;
                    m_pol = m_er;
                    m_tstamp = m_time;
                end else begin
                    m_ovf = 1'b1;
                end
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            m_time = m_time + 32'd1;
            if (m_wr && address == 3'd1) m_ctrl = writedata[3:0];
            if (m_wr && address == 3'd5) m_filter = writedata[7:0];
        end
    end

    // Hand-computed literal expectations, posted by the stimulus process.
    logic        chk_on = 1'b0;
    logic        lit_rd_en = 1'b0, lit_irq_en = 1'b0, lit_rd4_en = 1'b0;
    logic [31:0] lit_rd = 32'd0, lit_rd4 = 32'd0;
    logic        lit_irq = 1'b0;
    string       lit_name = "";

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            checks++;
            if (readdata !== m_rd) begin
                failures++;
                $display("FAIL model_readdata t=%0t addr=%0d got=0x%0h exp=0x%0h", $time, address, readdata, m_rd);
            end
            checks++;
            if (irq !== m_irq) begin
                failures++;
                $display("FAIL model_irq t=%0t got=%0b exp=%0b", $time, irq, m_irq);
            end
            checks++;
            if (readdata4 !== m_rd4) begin
                failures++;
                $display("FAIL model_readdata_cntw4 t=%0t addr=%0d got=0x%0h exp=0x%0h", $time, address, readdata4, m_rd4);
            end
            checks++;
            if (irq4 !== m_irq) begin
                failures++;
                $display("FAIL model_irq_cntw4 t=%0t got=%0b exp=%0b", $time, irq4, m_irq);
            end
        end
        if (lit_rd_en) begin
            checks++;
            if (readdata !== lit_rd) begin
                failures++;
                $display("FAIL %s: readdata got=0x%0h required=0x%0h", lit_name, readdata, lit_rd);
            end
        end
        if (lit_irq_en) begin
            checks++;
            if (irq !== lit_irq) begin
                failures++;
                $display("FAIL %s: irq got=%0b required=%0b", lit_name, irq, lit_irq);
            end
        end
        if (lit_rd4_en) begin
            checks++;
            if (readdata4 !== lit_rd4) begin
                failures++;
                $display("FAIL %s: readdata(CNT_W=4) got=0x%0h required=0x%0h", lit_name, readdata4, lit_rd4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input logic re, input logic [31:0] r, input logic ie, input logic i,
                       input logic r4e, input logic [31:0] r4, input string nm);
        lit_rd_en = re; lit_rd = r; lit_irq_en = ie; lit_irq = i;
        lit_rd4_en = r4e; lit_rd4 = r4; lit_name = nm;
        @(negedge clk);
        #1;
        lit_rd_en = 1'b0; lit_irq_en = 1'b0; lit_rd4_en = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] e, input string nm);
        address = a;
        tick();
        lit(1'b1, e, 1'b0, 1'b0, 1'b0, 32'd0, nm);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            address = 3'(i % 6);
            tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        chk_on = 1'b1;
        lit(1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0, "reset_outputs");
        reset_n = 1'b1;
        rd_chk(3'd5, 32'd4, "filter_reset");
        rd_chk(3'd1, 32'd0, "ctrl_reset");
        rd_chk(3'd2, 32'd0, "status_reset");

        // Rising edge with FILTER=4: captured 7 cycles after in_port rises.
        wr(3'd1, 32'hF);
        idle(4);
        address = 3'd2;
        in_port = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (j == 8) lit(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, "rise_latency_before");
            if (j == 9) lit(1'b1, 32'h5, 1'b1, 1'b1, 1'b0, 32'd0, "rise_latency_status_irq");
        end
        rd_chk(3'd3, 32'd1, "count_after_first_edge");
        rd_chk(3'd0, 32'd1, "data_high");
        in_port = 1'b0;
        idle(12);
        wr(3'd2, 32'h3);
        wr(3'd3, 32'h0);

        // Three-cycle glitch is rejected.
        in_port = 1'b1;
        repeat (3) tick();
        in_port = 1'b0;
        idle(12);
        rd_chk(3'd3, 32'd0, "glitch_count");
        rd_chk(3'd0, 32'd0, "glitch_data");

        // Two rising edges (falls disabled) without clearing.
        wr(3'd1, 32'hB);
        in_port = 1'b1; idle(12);
        in_port = 1'b0; idle(12);
        in_port = 1'b1; idle(12);
        rd_chk(3'd2, 32'h7, "two_rises_status");
        rd_chk(3'd3, 32'd2, "two_rises_count");
        address = 3'd4; idle(2);
        wr(3'd2, 32'h3);
        wr(3'd3, 32'h0);

        // Pending W1C coincident with a capture.
        wr(3'd1, 32'hF);
        in_port = 1'b0; idle(12);
        in_port = 1'b1;
        repeat (7) tick();
        wr(3'd2, 32'h1);
        rd_chk(3'd2, 32'h5, "w1c_vs_capture_status");
        rd_chk(3'd3, 32'd2, "w1c_vs_capture_count");
        address = 3'd4; idle(2);

        // FILTER=0, then a FILTER change while qualifying.
        wr(3'd5, 32'h0);
        wr(3'd2, 32'h3);
        in_port = 1'b0; idle(8);
        rd_chk(3'd0, 32'd0, "filter0_fall");
        wr(3'd5, 32'd10);
        in_port = 1'b1;
        repeat (4) tick();
        wr(3'd5, 32'd1);
        idle(6);
        rd_chk(3'd0, 32'd1, "filter_change_mid_qual");
        wr(3'd6, 32'hFFFF_FFFF);
        rd_chk(3'd6, 32'd0, "addr6_zero");
        rd_chk(3'd7, 32'd0, "addr7_zero");

        // Counter saturation in the CNT_W=4 instance.
        wr(3'd5, 32'h0);
        wr(3'd2, 32'h3);
        wr(3'd3, 32'h0);
        for (int e = 0; e < 20; e++) begin
            in_port = ~in_port;
            idle(5);
        end
        address = 3'd3;
        tick();
        lit(1'b1, 32'd20, 1'b0, 1'b0, 1'b1, 32'hF, "count_saturation");
        wr(3'd3, 32'h0);
        address = 3'd3;
        tick();
        lit(1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, "count_clear");

        // Reset in the middle of QUAL_HIGH with in_port held high.
        wr(3'd5, 32'd4);
        in_port = 1'b0; idle(12);
        in_port = 1'b1;
        repeat (4) tick();
        address = 3'd0;
        reset_n = 1'b0;
        repeat (2) tick();
        lit(1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0, "reset_mid_qual");
        reset_n = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (j == 8) lit(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "post_reset_before_edge");
            if (j == 9) lit(1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0, "post_reset_rise");
        end
        rd_chk(3'd5, 32'd4, "post_reset_filter");
        rd_chk(3'd1, 32'd0, "post_reset_ctrl");
        rd_chk(3'd2, 32'd0, "post_reset_status");
        rd_chk(3'd3, 32'd0, "post_reset_count");
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sma_in_edge_ctrl.md
SMA_IN_EDGE_CTRL -- requirements
Module: sma_in_edge_ctrl

Interface
REQ-001 SHALL have parameter FILTER_RST, default 8'd4: reset value of the glitch-filter length register.
REQ-002 SHALL have parameter CNT_W, default 16: event-counter width (1..32).
REQ-003 SHALL have port clk, input, 1: system clock.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_port, input, 1: raw asynchronous SMA input.
REQ-006 SHALL have port address, input, 3: Avalon-MM word address.
REQ-007 SHALL have port chipselect, input, 1: slave select.
REQ-008 SHALL have port write_n, input, 1: active-low write strobe, qualified by chipselect.
REQ-009 SHALL have port writedata, input, 32: write data.
REQ-010 SHALL have port readdata, output, 32: registered read data.
REQ-011 SHALL have port irq, output, 1: level interrupt.

Function
REQ-012 SHALL pass in_port through a 2-flop synchronizer to produce sync_in.
REQ-013 SHALL implement a filter FSM with states LOW, QUAL_HIGH, HIGH, QUAL_LOW; filtered level = 1 in HIGH and QUAL_LOW, else 0.
REQ-014 LOW->QUAL_HIGH when sync_in=1; HIGH->QUAL_LOW when sync_in=0; on entry the qualify counter loads 0.
REQ-015 In QUAL_x the counter SHALL increment each cycle sync_in holds the new value; at count==FILTER, move to the new level state and emit a one-cycle edge pulse; if sync_in reverts, return to the prior level state with no edge.
REQ-016 FILTER=0 SHALL accept a change one cycle after entering QUAL_x; total in_port-to-edge latency = 2 + FILTER + 1 cycles.
REQ-017 Register map: 0 DATA (RO, bit0 filtered level); 1 CTRL (RW: b0 enable, b1 rise_en, b2 fall_en, b3 irq_en); 2 STATUS (b0 pending W1C, b1 overflow W1C, b2 polarity of last captured edge RO); 3 COUNT (RO, write-any clears); 4 TIMESTAMP (RO); 5 FILTER (RW, bits[7:0]); 6-7 read 0, writes ignored.
REQ-018 An edge SHALL be captured only if enable=1 and its polarity's enable bit is set.
REQ-019 On capture with pending=0: set pending, record polarity, latch timestamp; with pending=1: set overflow, leave timestamp/polarity unchanged.
REQ-020 Every capture SHALL increment COUNT, saturating at 2^CNT_W-1.
REQ-021 Capture coincident with pending W1C SHALL leave pending=1 and latch the new timestamp/polarity; capture coincident with COUNT clear SHALL yield COUNT=1.
REQ-022 irq SHALL be registered, equal to irq_en & pending, asserted one cycle after pending sets.
REQ-023 readdata SHALL update every clk with the addressed register, zero-extended; reads have no side effects; 1-cycle latency.
REQ-024 The filter FSM SHALL run regardless of enable; clearing enable SHALL not alter STATUS, COUNT or TIMESTAMP.
REQ-025 A FILTER write while in QUAL_x SHALL take effect on the next comparison.

Reset
REQ-026 reset_n low SHALL asynchronously clear synchronizer, FSM (LOW), qualify counter, CTRL, STATUS, COUNT, TIMESTAMP, free-running counter, readdata and irq to 0, and set FILTER to FILTER_RST.
REQ-027 Deassertion SHALL produce no edge even if in_port is high; the FSM qualifies the high level and emits a rising edge only after the normal latency.

Configuration
REQ-028 Macro SMA_IN_TIMESTAMP_EN defined: a 32-bit free-running counter increments every clk, wrapping at 0xFFFFFFFF, and is latched into TIMESTAMP per REQ-019.
REQ-029 Macro SMA_IN_TIMESTAMP_EN undefined: no free-running counter or timestamp register is built; address 4 reads 0; all other behaviour identical.

Verification
REQ-030 FILTER=4, CTRL=0xF, in_port 0->1 held -> edge 7 cycles later, STATUS=0x5, COUNT=1, irq=1 next cycle.
REQ-031 FILTER=4, 3-cycle high glitch -> no edge, COUNT=0, DATA=0.
REQ-032 Two rising edges without clearing -> STATUS=0x7, COUNT=2, TIMESTAMP equal to first edge's counter value.
REQ-033 Write STATUS=0x1 in the same cycle as a new capture -> pending stays 1, TIMESTAMP updated.
REQ-034 CNT_W=4, 20 qualified edges -> COUNT=0xF; write COUNT -> 0.
REQ-035 reset_n pulsed low mid-QUAL_HIGH with in_port high -> all registers 0, FILTER=4, then exactly one rising edge 7 cycles after release.
